// File: rtl/loader_pkg.sv
// loader_pkg: shared state encoding, default depth and address shift
// for the instr_loader boot program loader.
package loader_pkg;

  // Loader FSM states; ST_CSUM is only reachable with LOADER_CHECKSUM_EN.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CSUM  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_RUN   = 3'd4,
    ST_ERROR = 3'd5
  } state_e;

  // Default instruction-cache capacity in 32-bit words.
  localparam int DEFAULT_DEPTH = 64;

  // Word index to byte address shift (4 bytes per instruction word).
  localparam int ADDR_SHIFT = 2;

endpackage

// File: rtl/instr_loader_if.sv
// instr_loader_if: valid/ready instruction stream feeding the loader.
// The master drives words, the slave (loader) returns in_ready.
interface instr_loader_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

// File: rtl/loader_checksum.sv
// loader_checksum: XOR accumulator over the written program words with
// clear, enable and an equality compare against the checksum beat.
// Only compiled when LOADER_CHECKSUM_EN is defined.
`ifdef LOADER_CHECKSUM_EN
module loader_checksum (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clr,
  input  logic        i_en,
  input  logic [31:0] i_data,
  input  logic [31:0] i_cmp_data,
  output logic        o_match
);

  logic [31:0] r_acc;

  // Accumulate each written word; cleared at the start of every load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_en) begin
      r_acc <= r_acc ^ i_data;
    end
  end

  assign o_match = (r_acc == i_cmp_data);

endmodule
`endif

// File: rtl/instr_loader.sv
// instr_loader: holds the core in reset, streams instruction words into
// the instruction cache from byte address 0, then releases the core.
// Optional feature macro: LOADER_CHECKSUM_EN (trailing XOR checksum beat).
module instr_loader
  import loader_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  instr_loader_if.slave     s,
  output logic              imem_we,
  output logic [31:0]       imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              done,
  output logic              error,
  output logic [CW-1:0]     word_count
);

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  state_e        r_state;
  logic          r_we;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic          r_core_rst;
  logic          r_done;
  logic          r_error;
  logic [CW-1:0] r_wc;

  logic w_accept;
  logic w_full;
  logic w_wr;
  logic w_start_ok;
  logic w_csum_match;

  // in_ready is the only output decoded straight from state.
  assign s.in_ready  = (r_state == ST_LOAD) || (r_state == ST_CSUM);
  assign w_accept    = s.in_valid && s.in_ready;
  assign w_full      = (r_wc == FULL_COUNT);
  assign w_wr        = w_accept && (r_state == ST_LOAD) && !w_full;
  assign w_start_ok  = start && (r_state inside {ST_IDLE, ST_RUN, ST_ERROR});

`ifdef LOADER_CHECKSUM_EN
  loader_checksum u_csum (
    .clk        (clk),
    .rst        (rst),
    .i_clr      (w_start_ok),
    .i_en       (w_wr),
    .i_data     (s.in_data),
    .i_cmp_data (s.in_data),
    .o_match    (w_csum_match)
  );
`else
  assign w_csum_match = 1'b0;
`endif

  // Loader FSM with registered write port and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_core_rst <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_wc       <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout; the write strobe defaults
      // low each cycle so every accepted word yields exactly one pulse.
      r_we <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state <= ST_LOAD;
            r_wc    <= '0;
          end
        end
        ST_LOAD: begin
          if (s.in_valid) begin
            if (w_full) begin
              // Overflow: drop the beat, never write past the cache.
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end else begin
              r_we    <= 1'b1;
              r_addr  <= 32'(r_wc) << ADDR_SHIFT;
              r_wdata <= s.in_data;
              r_wc    <= r_wc + CW'(1);
              if (s.in_last) begin
`ifdef LOADER_CHECKSUM_EN
                r_state <= ST_CSUM;
`else
                r_state <= ST_DRAIN;
`endif
              end
            end
          end
        end
`ifdef LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (s.in_valid) begin
            if (w_csum_match) begin
              r_state    <= ST_RUN;
              r_core_rst <= 1'b0;
              r_done     <= 1'b1;
            end else begin
              r_state <= ST_ERROR;
              r_error <= 1'b1;
            end
          end
        end
`endif
        ST_DRAIN: begin
          // Final write is on the bus this cycle; release afterwards.
          r_state    <= ST_RUN;
          r_core_rst <= 1'b0;
          r_done     <= 1'b1;
        end
        ST_RUN, ST_ERROR: begin
          if (start) begin
            r_state    <= ST_LOAD;
            r_wc       <= '0;
            r_core_rst <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign imem_we    = r_we;
  assign imem_addr  = r_addr;
  assign imem_wdata = r_wdata;
  assign core_rst   = r_core_rst;
  assign done       = r_done;
  assign error      = r_error;
  assign word_count = r_wc;

endmodule
